// File: rtl/alu_seq_pkg.sv
// Shared opcode and FSM state definitions for the sequential ALU.
package alu_seq_pkg;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_AND = 4'd2,
        OP_OR  = 4'd3,
        OP_XOR = 4'd4,
        OP_LSH = 4'd5,
        OP_RSH = 4'd6,
        OP_SEQ = 4'd7,
        OP_SLT = 4'd8,
        OP_MUL = 4'd9
    } op_mne;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } alu_seq_state_t;

endpackage

// File: rtl/alu_seq_core.sv
// Combinational single-cycle datapath; shifts pass A through (k=0 case),
// MUL and undefined opcodes yield zero.
module alu_seq_core
    import alu_seq_pkg::*;
#(
    parameter int W   = 8,
    parameter int Ops = 4
) (
    input  logic [W-1:0]   A,
    input  logic [W-1:0]   B,
    input  logic [Ops-1:0] OP,
    input  logic           SC_in,
    output logic [W-1:0]   result,
    output logic           carry
);

    localparam logic [Ops-1:0] C_ADD = Ops'(OP_ADD);
    localparam logic [Ops-1:0] C_SUB = Ops'(OP_SUB);
    localparam logic [Ops-1:0] C_AND = Ops'(OP_AND);
    localparam logic [Ops-1:0] C_OR  = Ops'(OP_OR);
    localparam logic [Ops-1:0] C_XOR = Ops'(OP_XOR);
    localparam logic [Ops-1:0] C_LSH = Ops'(OP_LSH);
    localparam logic [Ops-1:0] C_RSH = Ops'(OP_RSH);
    localparam logic [Ops-1:0] C_SEQ = Ops'(OP_SEQ);
    localparam logic [Ops-1:0] C_SLT = Ops'(OP_SLT);

    logic [W:0] w_sum;
    logic [W:0] w_diff;

    assign w_sum  = {1'b0, A} + {1'b0, B}  + {{W{1'b0}}, SC_in};
    assign w_diff = {1'b0, A} + {1'b0, ~B} + {{W{1'b0}}, 1'b1};

    always_comb begin
        result = '0;
        carry  = 1'b0;
        case (OP)
            C_ADD: begin
                result = w_sum[W-1:0];
                carry  = w_sum[W];
            end
            C_SUB: begin
                result = w_diff[W-1:0];
                carry  = w_diff[W];
            end
            C_AND:        result = A & B;
            C_OR:         result = A | B;
            C_XOR:        result = {{(W-1){1'b0}}, ^B};
            C_LSH, C_RSH: result = A;
            C_SEQ:        result = {{(W-1){1'b0}}, (A == B)};
            C_SLT:        result = {{(W-1){1'b0}}, (A < B)};
            default:      result = '0;
        endcase
    end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU with valid/ready handshake; iterative shifts and an optional
// shift-add multiplier enabled by the ALU_SEQ_MUL_EN macro.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int W   = 8,
    parameter int Ops = 4
) (
    input  logic           Clk,
    input  logic           Reset_n,
    input  logic           InValid,
    output logic           InReady,
    input  logic [W-1:0]   InputA,
    input  logic [W-1:0]   InputB,
    input  logic [Ops-1:0] OP,
    input  logic           SC_in,
    output logic           OutValid,
    input  logic           OutReady,
    output logic [W-1:0]   Out,
    output logic           Zero,
    output logic           Carry
);

    localparam int CW = $clog2(W + 1);
    localparam logic [Ops-1:0] C_LSH = Ops'(OP_LSH);
    localparam logic [Ops-1:0] C_RSH = Ops'(OP_RSH);
`ifdef ALU_SEQ_MUL_EN
    localparam logic [Ops-1:0] C_MUL = Ops'(OP_MUL);
`endif

    alu_seq_state_t r_state, w_state_nxt;

    logic           r_init;
    logic [Ops-1:0] r_op;
    logic [W-1:0]   r_acc;
    logic [CW-1:0]  r_cnt;
    logic [W-1:0]   r_out;
    logic           r_zero;
    logic           r_carry;

    logic [W-1:0]   w_core_res;
    logic           w_core_carry;
    logic           w_accept;
    logic           w_shift_go;
    logic           w_mul_go;
    logic           w_iter_go;
    logic           w_last;
    logic [W-1:0]   w_step_acc;
    logic           w_step_co;

`ifdef ALU_SEQ_MUL_EN
    logic [W-1:0]   r_a;
    logic [W-1:0]   r_hi;
    logic [W:0]     w_mul_sum;
    logic [W-1:0]   w_step_hi;
`endif

    alu_seq_core #(
        .W   (W),
        .Ops (Ops)
    ) u_core (
        .A      (InputA),
        .B      (InputB),
        .OP     (OP),
        .SC_in  (SC_in),
        .result (w_core_res),
        .carry  (w_core_carry)
    );

    assign w_accept   = InValid && InReady;
    assign w_shift_go = ((OP == C_LSH) || (OP == C_RSH)) && (InputB != '0);
`ifdef ALU_SEQ_MUL_EN
    assign w_mul_go   = (OP == C_MUL);
`else
    assign w_mul_go   = 1'b0;
`endif
    assign w_iter_go  = w_shift_go || w_mul_go;
    assign w_last     = (r_cnt == CW'(1));

    assign Out   = r_out;
    assign Zero  = r_zero;
    assign Carry = r_carry;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) r_state <= IDLE;
        else          r_state <= w_state_nxt;
    end

    // InReady stays low until the first edge after reset release.
    always_comb begin
        w_state_nxt = r_state;
        InReady     = 1'b0;
        OutValid    = 1'b0;
        case (r_state)
            IDLE: begin
                InReady = r_init;
                if (InValid && r_init) w_state_nxt = w_iter_go ? BUSY : DONE;
            end
            BUSY: if (w_last) w_state_nxt = DONE;
            DONE: begin
                OutValid = 1'b1;
                if (OutReady) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_step_acc = r_acc;
        w_step_co  = 1'b0;
`ifdef ALU_SEQ_MUL_EN
        w_mul_sum  = '0;
        w_step_hi  = r_hi;
`endif
        if (r_op == C_LSH) begin
            w_step_acc = {r_acc[W-2:0], 1'b0};
            w_step_co  = r_acc[W-1];
        end else if (r_op == C_RSH) begin
            w_step_acc = {1'b0, r_acc[W-1:1]};
            w_step_co  = r_acc[0];
`ifdef ALU_SEQ_MUL_EN
        end else begin
            // {hi,lo} holds the partial product; lo starts as the multiplier.
            w_mul_sum  = {1'b0, r_hi} + (r_acc[0] ? {1'b0, r_a} : '0);
            {w_step_hi, w_step_acc} = {w_mul_sum, r_acc[W-1:1]};
            w_step_co  = |w_step_hi;
`endif
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_init  <= 1'b0;
            r_op    <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_out   <= '0;
            r_zero  <= 1'b0;
            r_carry <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
            r_a     <= '0;
            r_hi    <= '0;
`endif
        end else begin
            r_init <= 1'b1;
            if (w_accept) begin
                r_op    <= OP;
                r_acc   <= InputA;
                r_out   <= w_core_res;
                r_zero  <= (w_core_res == '0);
                r_carry <= w_core_carry;
                if (w_shift_go)
                    r_cnt <= (InputB >= W'(W)) ? CW'(W) : CW'(InputB);
`ifdef ALU_SEQ_MUL_EN
                if (w_mul_go) begin
                    r_acc <= InputB;
                    r_a   <= InputA;
                    r_hi  <= '0;
                    r_cnt <= CW'(W);
                end
`endif
            end else if (r_state == BUSY) begin
                r_acc <= w_step_acc;
                r_cnt <= r_cnt - CW'(1);
`ifdef ALU_SEQ_MUL_EN
                r_hi  <= w_step_hi;
`endif
                if (w_last) begin
                    r_out   <= w_step_acc;
                    r_zero  <= (w_step_acc == '0);
                    r_carry <= w_step_co;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq (W=8); MUL expectations follow ALU_SEQ_MUL_EN.
module tb_alu_seq;
    import alu_seq_pkg::*;

    logic       Clk;
    logic       Reset_n;
    logic       InValid;
    logic       InReady;
    logic [7:0] InputA;
    logic [7:0] InputB;
    logic [3:0] OP;
    logic       SC_in;
    logic       OutValid;
    logic       OutReady;
    logic [7:0] Out;
    logic       Zero;
    logic       Carry;

    int checks = 0;
    int errors = 0;

    alu_seq #(
        .W   (8),
        .Ops (4)
    ) dut (
        .Clk      (Clk),
        .Reset_n  (Reset_n),
        .InValid  (InValid),
        .InReady  (InReady),
        .InputA   (InputA),
        .InputB   (InputB),
        .OP       (OP),
        .SC_in    (SC_in),
        .OutValid (OutValid),
        .OutReady (OutReady),
        .Out      (Out),
        .Zero     (Zero),
        .Carry    (Carry)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                          input logic sc, output int lat);
        OP = op; InputA = a; InputB = b; SC_in = sc; InValid = 1'b1;
        @(posedge Clk); #1;
        InValid = 1'b0;
        lat = 1;
        while (!OutValid && lat < 50) begin
            @(posedge Clk); #1;
            lat++;
        end
    endtask

    task automatic take();
        OutReady = 1'b1;
        @(posedge Clk); #1;
        OutReady = 1'b0;
    endtask

    task automatic op_test(input string tag, input logic [3:0] op, input logic [7:0] a,
                           input logic [7:0] b, input logic sc, input int elat,
                           input logic [7:0] eout, input logic ez, input logic ec);
        int lat;
        check({tag, "_ready"}, {31'd0, InReady}, 32'd1);
        run_op(op, a, b, sc, lat);
        check({tag, "_lat"},   lat, elat);
        check({tag, "_out"},   {24'd0, Out}, {24'd0, eout});
        check({tag, "_zero"},  {31'd0, Zero}, {31'd0, ez});
        check({tag, "_carry"}, {31'd0, Carry}, {31'd0, ec});
        take();
        check({tag, "_idle"},  {31'd0, OutValid}, 32'd0);
    endtask

    initial begin
        int lat;
        int seen;
        Reset_n = 1'b0; InValid = 1'b0; OutReady = 1'b0;
        InputA = '0; InputB = '0; OP = '0; SC_in = 1'b0;

        // Reset state
        #2;
        check("rst_ready", {31'd0, InReady}, 32'd0);
        check("rst_valid", {31'd0, OutValid}, 32'd0);
        check("rst_out",   {24'd0, Out}, 32'd0);
        check("rst_flags", {30'd0, Zero, Carry}, 32'd0);
        @(posedge Clk); #1;
        check("rst_ready_edge", {31'd0, InReady}, 32'd0);
        #2 Reset_n = 1'b1;
        #1 check("rel_ready_pre", {31'd0, InReady}, 32'd0);
        @(posedge Clk); #1;
        check("rel_ready_post", {31'd0, InReady}, 32'd1);

        // Single-cycle ops
        op_test("add_ff_01", OP_ADD, 8'hFF, 8'h01, 1'b0, 1, 8'h00, 1'b1, 1'b1);
        op_test("add_cin",   OP_ADD, 8'h10, 8'h20, 1'b1, 1, 8'h31, 1'b0, 1'b0);
        op_test("sub_7_5",   OP_SUB, 8'h07, 8'h05, 1'b0, 1, 8'h02, 1'b0, 1'b1);
        op_test("and",       OP_AND, 8'hF0, 8'h3C, 1'b0, 1, 8'h30, 1'b0, 1'b0);
        op_test("or",        OP_OR,  8'hF0, 8'h0C, 1'b0, 1, 8'hFC, 1'b0, 1'b0);
        op_test("xor_odd",   OP_XOR, 8'h00, 8'h07, 1'b0, 1, 8'h01, 1'b0, 1'b0);
        op_test("xor_even",  OP_XOR, 8'hFF, 8'h03, 1'b0, 1, 8'h00, 1'b1, 1'b0);
        op_test("undef_op",  4'hF,   8'hFF, 8'hFF, 1'b1, 1, 8'h00, 1'b1, 1'b0);

        // Iterative shifts
        op_test("lsh_81_3",  OP_LSH, 8'h81, 8'h03, 1'b0, 4, 8'h08, 1'b0, 1'b0);
        op_test("rsh_81_9",  OP_RSH, 8'h81, 8'h09, 1'b0, 9, 8'h00, 1'b1, 1'b1);
        op_test("lsh_b0",    OP_LSH, 8'h5A, 8'h00, 1'b0, 1, 8'h5A, 1'b0, 1'b0);
        op_test("rsh_18_4",  OP_RSH, 8'h18, 8'h04, 1'b0, 5, 8'h01, 1'b0, 1'b1);
        op_test("lsh_big",   OP_LSH, 8'hFF, 8'hC8, 1'b0, 9, 8'h00, 1'b1, 1'b1);

`ifdef ALU_SEQ_MUL_EN
        op_test("mul",       OP_MUL, 8'h10, 8'h20, 1'b0, 9, 8'h00, 1'b1, 1'b1);
        op_test("mul_small", OP_MUL, 8'h0D, 8'h0B, 1'b0, 9, 8'h8F, 1'b0, 1'b0);
`else
        op_test("mul_off",   OP_MUL, 8'h10, 8'h20, 1'b0, 1, 8'h00, 1'b1, 1'b0);
`endif

        // SUB held in DONE with OutReady low; InValid pulses ignored
        run_op(OP_SUB, 8'h05, 8'h07, 1'b0, lat);
        check("hold_lat", lat, 1);
        for (int i = 0; i < 10; i++) begin
            OP = OP_ADD; InputA = 8'h01; InputB = 8'h01; InValid = (i % 2 == 0);
            @(posedge Clk); #1;
            check("hold_out",   {24'd0, Out}, 32'h0000_00FE);
            check("hold_ready", {31'd0, InReady}, 32'd0);
            check("hold_valid", {31'd0, OutValid}, 32'd1);
        end
        InValid = 1'b0;
        check("hold_carry", {31'd0, Carry}, 32'd0);
        take();
        check("hold_released", {30'd0, OutValid, InReady}, 32'd1);

        // Reset in the third BUSY cycle of LSH B=6
        OP = OP_LSH; InputA = 8'h81; InputB = 8'h06; InValid = 1'b1;
        @(posedge Clk); #1;
        InValid = 1'b0;
        @(posedge Clk); #1;
        @(posedge Clk); #1;
        check("midrst_busy", {31'd0, OutValid}, 32'd0);
        Reset_n = 1'b0;
        #1;
        check("midrst_out",   {24'd0, Out}, 32'd0);
        check("midrst_flags", {30'd0, Zero, Carry}, 32'd0);
        check("midrst_ready", {31'd0, InReady}, 32'd0);
        #2 Reset_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge Clk); #1;
            if (OutValid) seen++;
        end
        check("midrst_no_valid", seen, 0);
        op_test("post_rst_add", OP_ADD, 8'h02, 8'h03, 1'b0, 1, 8'h05, 1'b0, 1'b0);

        // Back-to-back with OutReady held high
        OutReady = 1'b1;
        OP = OP_ADD; InputA = 8'h01; InputB = 8'h02; SC_in = 1'b0; InValid = 1'b1;
        @(posedge Clk); #1;
        check("b2b_add_valid", {31'd0, OutValid}, 32'd1);
        check("b2b_add_out",   {24'd0, Out}, 32'd3);
        OP = OP_SEQ; InputA = 8'h07; InputB = 8'h07;
        @(posedge Clk); #1;
        check("b2b_gap1", {30'd0, OutValid, InReady}, 32'd1);
        @(posedge Clk); #1;
        check("b2b_seq_valid", {31'd0, OutValid}, 32'd1);
        check("b2b_seq_out",   {24'd0, Out}, 32'd1);
        OP = OP_SLT; InputA = 8'h09; InputB = 8'h03;
        @(posedge Clk); #1;
        check("b2b_gap2", {30'd0, OutValid, InReady}, 32'd1);
        @(posedge Clk); #1;
        InValid = 1'b0;
        check("b2b_slt_valid", {31'd0, OutValid}, 32'd1);
        check("b2b_slt_out",   {24'd0, Out}, 32'd0);
        check("b2b_slt_zero",  {31'd0, Zero}, 32'd1);
        @(posedge Clk); #1;
        OutReady = 1'b0;
        check("b2b_end", {30'd0, OutValid, InReady}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have parameter W, default 8: data width in bits, legal range 4..32.
REQ-002 SHALL have parameter Ops, default 4: opcode width in bits.
REQ-003 SHALL have ports Clk (input, 1, clock) and Reset_n (input, 1): one clock; reset is asynchronous and active-low.
REQ-004 SHALL have InValid (input, 1): an operation is offered.
REQ-005 SHALL have InReady (output, 1): the block accepts an operation.
REQ-006 SHALL have InputA and InputB (input, W): operands; InputB is also the shift amount.
REQ-007 SHALL have OP (input, Ops): opcode, type op_mne.
REQ-008 SHALL have SC_in (input, 1): carry-in for ADD.
REQ-009 SHALL have OutValid (output, 1): the result is available.
REQ-010 SHALL have OutReady (input, 1): the consumer takes the result.
REQ-011 SHALL have Out (output, W): result.
REQ-012 SHALL have Zero and Carry (output, 1 each): result flags.

Function
REQ-013 SHALL implement a 3-state FSM: IDLE -> (accept) BUSY or DONE; BUSY -> DONE when the iteration count is exhausted; DONE -> (OutValid && OutReady) IDLE.
REQ-014 SHALL drive InReady=1 only in IDLE; an accept is InValid && InReady on a rising Clk edge, and operands and OP are latched at that edge.
REQ-015 SHALL drive OutValid=1 only in DONE, holding Out, Zero and Carry stable until the handshake completes.
REQ-016 SHALL give latency 1 for single-cycle ops: an accept at edge t produces OutValid after edge t+1.
REQ-017 Single-cycle ops SHALL compute as follows: ADD = A+B+SC_in; SUB = A+~B+1; AND; OR; XOR = reduction XOR of B, zero-extended; SEQ = (A==B); SLT = unsigned A<B, zero-extended.
REQ-018 LSH and RSH SHALL be iterative at one bit per cycle over k = min(B, W) iterations, producing OutValid after edge t+1+k.
REQ-019 A shift with B=0 SHALL return A with latency 1, and a shift with B>=W SHALL return 0.
REQ-020 Carry SHALL be the carry-out of bit W-1 for ADD and SUB, the last bit shifted out for shifts (0 when k=0), and 0 for all other ops.
REQ-021 Zero SHALL equal (Out==0) for every op.
REQ-022 An undefined opcode SHALL return Out=0, Zero=1, Carry=0 with latency 1.
REQ-023 InValid asserted while the FSM is not in IDLE SHALL be ignored, and the in-flight operation SHALL be unaffected.
REQ-024 When OutReady is held low, the FSM SHALL stay in DONE indefinitely.
REQ-025 When OutReady is already high on entry to DONE, the handshake SHALL complete on the next edge, giving a minimum 2-cycle issue interval.
REQ-026 Arithmetic SHALL use W+1 internal bits, and Out SHALL be the low W bits.

Reset
REQ-027 Reset_n low SHALL immediately force IDLE with Out=0, Zero=0, Carry=0, OutValid=0 and the iteration counter cleared.
REQ-028 While Reset_n is low, InReady SHALL be 0.
REQ-029 InReady SHALL rise after the first Clk edge with Reset_n high.
REQ-030 Reset asserted mid-operation (BUSY or DONE) SHALL discard the operation, and no OutValid SHALL follow it.

Configuration
REQ-031 The macro ALU_SEQ_MUL_EN SHALL select the MUL opcode.
REQ-032 With ALU_SEQ_MUL_EN defined, MUL SHALL be an iterative unsigned shift-add over W cycles (latency W+1), with Out = the low W bits of A*B and Carry = 1 if the high W bits are nonzero.
REQ-033 Without ALU_SEQ_MUL_EN, MUL SHALL behave as an undefined opcode (REQ-022) and no multiplier logic SHALL be built.

Structure
REQ-034 The package definitions SHALL hold: op_mne (ADD=0, SUB=1, AND=2, OR=3, XOR=4, LSH=5, RSH=6, SEQ=7, SLT=8, MUL=9) and alu_seq_state_t (IDLE, BUSY, DONE).
REQ-035 The single-cycle datapath SHALL be the combinational sub-module alu_seq_core (inputs A, B, OP, SC_in; outputs result and carry); alu_seq SHALL hold the FSM, counter, shift/MUL registers and handshake.

Verification
REQ-036 ADD A=8'hFF, B=8'h01, SC_in=0 -> after 1 cycle Out=8'h00, Zero=1, Carry=1.
REQ-037 LSH A=8'h81, B=3 -> OutValid exactly 4 cycles after accept, Out=8'h08, Carry=0 (last bit shifted out); RSH A=8'h81, B=9 -> Out=0, latency 9.
REQ-038 SUB A=5, B=7 with OutReady held low for 10 cycles -> Out=8'hFE held stable, InReady=0 throughout, InValid pulses ignored.
REQ-039 With ALU_SEQ_MUL_EN: MUL A=8'h10, B=8'h20 -> Out=8'h00, Carry=1, Zero=1, latency 9; without ALU_SEQ_MUL_EN -> Out=0, latency 1.
REQ-040 Reset_n pulsed low during the third BUSY cycle of LSH B=6 -> outputs zero immediately, no OutValid, and the next ADD 2+3 returns 5.
REQ-041 Back-to-back ADD/SEQ/SLT with OutReady=1 -> one result every 2 cycles, SEQ 7,7 -> 1, SLT 9,3 -> 0.
